// File: rtl/branch_redirect_unit.sv
// Fetch-side PC owner: applies ID-stage taken predictions, tracks predicted branches
// in a small FIFO until ALU resolution, and redirects/flushes on a mispredict.
module branch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             id_branch_valid,
  input  logic             id_predict_taken,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      id_target,
  input  logic             alu_branch_valid,
  input  logic             alu_branch_taken,
  output logic [31:0]      pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             mispredict,
  output logic             q_error,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(QDEPTH);

  logic [QDEPTH-1:0] pred_q;
  logic [31:0]       fall_q [QDEPTH];
  logic [31:0]       tgt_q  [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [31:0]       pc_q, pc_d;
  logic              qerr_q, qerr_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d, mcnt_q, mcnt_d;

  logic empty_s, full_s, pop_s, push_req_s, push_s, overflow_s, underflow_s;
  logic head_pred_s;
  logic [31:0] head_fall_s, head_tgt_s;

  assign empty_s     = (occ_q == '0);
  assign full_s      = (occ_q == OCC_FULL);
  assign head_pred_s = pred_q[rd_ptr_q];
  assign head_fall_s = fall_q[rd_ptr_q];
  assign head_tgt_s  = tgt_q[rd_ptr_q];

  // An empty queue never yields a mispredict, so a stray resolve cannot redirect.
  assign pop_s       = alu_branch_valid & ~empty_s;
  assign mispredict  = pop_s & (head_pred_s != alu_branch_taken);
  assign push_req_s  = id_branch_valid & ~stall & ~mispredict;
  assign push_s      = push_req_s & (~full_s | pop_s);
  assign overflow_s  = push_req_s & full_s & ~pop_s;
  assign underflow_s = alu_branch_valid & empty_s;

  assign flush_if_id = mispredict | (id_branch_valid & id_predict_taken & ~stall);
  assign flush_id_ex = mispredict;

  assign pc               = pc_q;
  assign q_error          = qerr_q;
  assign branch_count     = bcnt_q;
  assign mispredict_count = mcnt_q;

  always_comb begin
    pc_d = pc_q + 32'd4;
    if (mispredict) begin
      pc_d = alu_branch_taken ? head_tgt_s : head_fall_s;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (id_branch_valid && id_predict_taken) begin
      pc_d = id_target;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  // A mispredict squashes every remaining entry: they are all wrong-path.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (mispredict) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
      case ({push_s, pop_s})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_comb begin
    qerr_d = qerr_q | overflow_s | underflow_s;
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (alu_branch_valid && !(&bcnt_q)) begin
      bcnt_d = bcnt_q + CNT_W'(1);
    end else begin
      bcnt_d = bcnt_q;
    end
    if (mispredict && !(&mcnt_q)) begin
      mcnt_d = mcnt_q + CNT_W'(1);
    end else begin
      mcnt_d = mcnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      qerr_q   <= 1'b0;
      bcnt_q   <= '0;
      mcnt_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      qerr_q   <= qerr_d;
      bcnt_q   <= bcnt_d;
      mcnt_q   <= mcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pred_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        fall_q[i] <= 32'd0;
        tgt_q[i]  <= 32'd0;
      end
    end else if (push_s) begin
      pred_q[wr_ptr_q] <= id_predict_taken;
      fall_q[wr_ptr_q] <= id_pc + 32'd4;
      tgt_q[wr_ptr_q]  <= id_target;
    end
  end
endmodule

// File: tb/tb_branch_redirect_unit.sv
// Table-driven bench for branch_redirect_unit: one row per cycle, expectations queued
// when a row is driven and compared at the following falling edge.
module tb_branch_redirect_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1, stall = 1'b0;
  logic        id_branch_valid = 1'b0, id_predict_taken = 1'b0;
  logic [31:0] id_pc = 32'd0, id_target = 32'd0;
  logic        alu_branch_valid = 1'b0, alu_branch_taken = 1'b0;
  logic [31:0] pc;
  logic        flush_if_id, flush_id_ex, mispredict, q_error;
  logic [3:0]  branch_count, mispredict_count;

  int checks = 0;
  int errors = 0;

  branch_redirect_unit #(.RESET_PC(32'h0000_0100), .QDEPTH(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .id_branch_valid(id_branch_valid), .id_predict_taken(id_predict_taken),
    .id_pc(id_pc), .id_target(id_target),
    .alu_branch_valid(alu_branch_valid), .alu_branch_taken(alu_branch_taken),
    .pc(pc), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .mispredict(mispredict), .q_error(q_error),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stl, idv, idpt;
    logic [31:0] idpc, idtgt;
    logic        aluv, alut;
    logic        chk;
    logic [31:0] epc;
    logic        efif, efie, emis, eqerr;
    logic [3:0]  ebc, emc;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t v(logic rst, logic stl, logic idv, logic idpt,
                             logic [31:0] idpc, logic [31:0] idtgt, logic aluv, logic alut,
                             logic [31:0] epc, logic efif, logic efie, logic emis,
                             logic eqerr, logic [3:0] ebc, logic [3:0] emc);
    vec_t r;
    r.rst = rst; r.stl = stl; r.idv = idv; r.idpt = idpt; r.idpc = idpc; r.idtgt = idtgt;
    r.aluv = aluv; r.alut = alut; r.chk = 1'b1; r.epc = epc; r.efif = efif; r.efie = efie;
    r.emis = emis; r.eqerr = eqerr; r.ebc = ebc; r.emc = emc;
    return r;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  // Drive one row after the rising edge, compare at the falling edge of the same cycle.
  task automatic apply(input vec_t r, input int row);
    vec_t e;
    @(posedge clk);
    #1;
    reset = r.rst; stall = r.stl; id_branch_valid = r.idv; id_predict_taken = r.idpt;
    id_pc = r.idpc; id_target = r.idtgt; alu_branch_valid = r.aluv; alu_branch_taken = r.alut;
    exp_q.push_back(r);
    @(negedge clk);
    e = exp_q.pop_front();
    if (e.chk) begin
      chk("pc", row, pc, e.epc);
      chk("flush_if_id", row, {31'd0, flush_if_id}, {31'd0, e.efif});
      chk("flush_id_ex", row, {31'd0, flush_id_ex}, {31'd0, e.efie});
      chk("mispredict", row, {31'd0, mispredict}, {31'd0, e.emis});
      chk("q_error", row, {31'd0, q_error}, {31'd0, e.eqerr});
      chk("branch_count", row, {28'd0, branch_count}, {28'd0, e.ebc});
      chk("mispredict_count", row, {28'd0, mispredict_count}, {28'd0, e.emc});
    end
  endtask

  initial begin
    vec_t r;
    int bc;
    // rst stl idv pt idpc idtgt aluv alut | pc fif fie mis qerr bc mc
    r = v(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0); r.chk = 1'b0; tbl.push_back(r);
    tbl.push_back(v(1,0,0,0,0,0,0,0, 32'h100,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0, 32'h100,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0, 32'h104,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0, 32'h108,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0, 32'h10C,0,0,0,0,0,0));
    // correct not-taken
    tbl.push_back(v(0,0,1,0,32'h200,32'h240,0,0, 32'h110,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,1,0, 32'h114,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0, 32'h118,0,0,0,0,1,0));
    // predicted taken, actually not taken
    tbl.push_back(v(0,0,1,1,32'h300,32'h380,0,0, 32'h11C,1,0,0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,0,1,0, 32'h380,1,1,1,0,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0, 32'h304,0,0,0,0,2,1));
    // two not-taken predictions queued, first resolves taken under stall
    tbl.push_back(v(0,0,1,0,32'h400,32'h420,0,0, 32'h308,0,0,0,0,2,1));
    tbl.push_back(v(0,0,1,0,32'h500,32'h540,0,0, 32'h30C,0,0,0,0,2,1));
    tbl.push_back(v(0,1,0,0,0,0,1,1, 32'h310,1,1,1,0,2,1));
    tbl.push_back(v(0,0,0,0,0,0,0,0, 32'h420,0,0,0,0,3,2));
    // queue must now be empty: resolve is ignored and flags an error
    tbl.push_back(v(0,0,0,0,0,0,1,1, 32'h424,0,0,0,0,3,2));
    tbl.push_back(v(0,0,0,0,0,0,0,0, 32'h428,0,0,0,1,4,2));
    tbl.push_back(v(1,0,0,0,0,0,0,0, 32'h42C,0,0,0,1,4,2));
    // overflow: third push dropped, then the two kept entries pop in order
    tbl.push_back(v(0,0,1,0,32'h600,32'h640,0,0, 32'h100,0,0,0,0,0,0));
    tbl.push_back(v(0,0,1,0,32'h610,32'h650,0,0, 32'h104,0,0,0,0,0,0));
    tbl.push_back(v(0,0,1,1,32'h620,32'h660,0,0, 32'h108,1,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0, 32'h660,0,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0,1,0, 32'h664,0,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0,1,1, 32'h668,1,1,1,1,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0, 32'h650,0,0,0,1,2,1));
    tbl.push_back(v(1,0,0,0,0,0,0,0, 32'h654,0,0,0,1,2,1));
    // pop while empty right after reset
    tbl.push_back(v(0,0,0,0,0,0,1,1, 32'h100,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0, 32'h104,0,0,0,1,1,0));
    // reset discards an in-flight entry
    tbl.push_back(v(0,0,1,1,32'h700,32'h780,0,0, 32'h108,1,0,0,1,1,0));
    tbl.push_back(v(1,0,0,0,0,0,0,0, 32'h780,0,0,0,1,1,0));
    tbl.push_back(v(0,0,0,0,0,0,1,0, 32'h100,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0, 32'h104,0,0,0,1,1,0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Counter saturation: 20 branches, each predicted not-taken and resolved taken.
    apply(v(1,0,0,0,0,0,0,0, 32'h108,0,0,0,1,1,0), 100);
    for (int i = 0; i < 20; i++) begin
      bc = (i > 15) ? 15 : i;
      apply(v(0,0,1,0,32'h800,32'h800,0,0, (i == 0) ? 32'h100 : 32'h800,0,0,0,0,
              4'(bc),4'(bc)), 200 + 2*i);
      apply(v(0,0,0,0,0,0,1,1, (i == 0) ? 32'h104 : 32'h804,1,1,1,0,4'(bc),4'(bc)), 201 + 2*i);
    end
    apply(v(0,0,0,0,0,0,0,0, 32'h800,0,0,0,0,15,15), 300);

    // PC wrap at the top of the address space.
    apply(v(0,0,1,1,32'h900,32'hFFFF_FFFC,0,0, 32'h804,1,0,0,0,15,15), 301);
    apply(v(0,0,0,0,0,0,0,0, 32'hFFFF_FFFC,0,0,0,0,15,15), 302);
    apply(v(0,0,0,0,0,0,0,0, 32'h0000_0000,0,0,0,0,15,15), 303);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_redirect_unit.md
# branch_redirect_unit

Fetch-side partner of the branch hazard unit. It owns the program counter and applies the predictor's ID-stage "take branch" decision. It tracks each predicted branch in a small in-flight queue until that branch resolves in the ALU stage. On a mispredict it redirects the PC to the correct address and flushes the IF/ID and ID/EX pipeline registers, and it keeps saturating branch and mispredict counters.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- QDEPTH, 2, in-flight branch queue depth (power of two, ≥2)
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  load-use stall from the hazard unit; hold PC and suppress the queue push
- id_branch_valid  in  1  ID-stage instruction is a conditional branch
- id_predict_taken  in  1  predictor decision for that branch (1 = taken)
- id_pc  in  32  PC of the ID-stage branch
- id_target  in  32  id_pc + B-immediate from the ID-stage adder
- alu_branch_valid  in  1  a branch is resolving in the ALU stage this cycle
- alu_branch_taken  in  1  actual outcome of that branch
- pc  out  32  current fetch PC (registered)
- flush_if_id  out  1  squash the IF/ID register at the next edge
- flush_id_ex  out  1  squash the ID/EX register at the next edge
- mispredict  out  1  ALU-stage resolution disagrees with the recorded prediction
- q_error  out  1  sticky: queue overflow or pop-when-empty
- branch_count  out  CNT_W  resolved branches, saturating
- mispredict_count  out  CNT_W  mispredicts, saturating

## Operation
- Queue entry: {pred_taken, fallthrough = id_pc+4, target = id_target}. FIFO order, QDEPTH entries, wrap-around pointers plus an occupancy count.
- Push condition: id_branch_valid & ~stall & ~mispredict.
- Pop condition: alu_branch_valid. The head entry supplies pred_taken, fallthrough and target.
- Mispredict: mispredict = alu_branch_valid & (head.pred_taken != alu_branch_taken). Combinational.
- Correct address on a mispredict: head.target if alu_branch_taken, else head.fallthrough.
- Next-PC priority, highest first:
  1. mispredict: load the correct address.
  2. stall: hold pc.
  3. id_branch_valid & id_predict_taken: load id_target.
  4. Otherwise: pc+4. All adds are modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Flush outputs (combinational):
  - flush_if_id = mispredict | (id_branch_valid & id_predict_taken & ~stall)
  - flush_id_ex = mispredict
- On a mispredict, all queue entries are squashed because every remaining entry is wrong-path. Occupancy becomes 0 and no push occurs that cycle.
- Push and pop in the same cycle without a mispredict: both take effect, and occupancy is unchanged.
- Push while full: the entry is dropped and q_error is set.
- Pop while empty: mispredict is forced to 0, pc is not redirected, and q_error is set. branch_count still increments.
- Counters:
  - branch_count += 1 on each alu_branch_valid.
  - mispredict_count += 1 on each mispredict.
  - Both hold at 2^CNT_W−1.

## Timing
- Reset (synchronous, high at the edge):
  - pc = RESET_PC, queue empty, q_error = 0, both counters = 0.
  - Combinational outputs evaluate against the empty queue.
- Reset mid-operation discards all in-flight entries. No redirect is produced from pre-reset state.
- Predicted-taken redirect: the branch is in ID in cycle N, pc = id_target in cycle N+1, and the IF/ID slot is flushed. This is a 1-bubble penalty.
- Mispredict: the branch is in ALU in cycle N. In cycle N+1, pc = the correct address and IF/ID and ID/EX are squashed. This is a 2-bubble penalty.
- With no stalls, a branch pushed in cycle N pops in cycle N+1. QDEPTH=2 covers one stall cycle of slack.
- A mispredict in the same cycle as stall: the mispredict wins and pc redirects.
- q_error and the counters update at the edge following the triggering cycle.

## Test plan
- Reset sequencing: reset high for 2 cycles with RESET_PC = 32'h0000_0100, then idle for 3 cycles -> pc = 0x100, 0x104, 0x108, 0x10C; flushes 0; counters 0.
- Correct not-taken branch: ID branch at 0x200, predict 0, target 0x240; the next cycle ALU resolves not-taken -> no flush, pc keeps incrementing, branch_count = 1, mispredict_count = 0.
- Predicted taken, actually not taken: ID branch at 0x300 predict 1, target 0x380 -> flush_if_id=1, pc=0x380. Next cycle ALU resolves not-taken -> mispredict=1, both flushes=1, pc=0x304, mispredict_count=1.
- Predicted not taken, actually taken, mispredict during stall: ID branch at 0x400 predict 0, target 0x420; ALU resolves taken while stall=1 -> pc=0x420, queue empty, flush_id_ex=1.
- Queue boundaries: hold stall=0 and push three branches with no pops (QDEPTH=2) -> third push dropped and q_error=1. After reset, an ALU resolve with the queue empty -> mispredict=0, q_error=1.
- Counter saturation: with CNT_W=4, resolve 20 branches, all mispredicted -> both counters stop at 15. PC wrap: pc at 0xFFFF_FFFC with no branch -> pc becomes 0.
